// File: rtl/fifo_pkg.sv
// Shared helpers for the sync FIFO family: count-width sizing and read-mode encoding.
// No state, no latency; pure compile-time definitions.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Width needed to hold the values 0..depth inclusive.
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read data follows raddr combinationally.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO of any depth: std (dout one edge after pop) or FWFT read, thresholds, flush, sticky errors.
// A push is visible one edge after it is accepted; push at full is taken only when a pop is accepted alongside it.
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 16,
  parameter int   FWFT     = 0,
  parameter int   AF_LEVEL = DEPTH - 2,
  parameter int   AE_LEVEL = 2,
  localparam int  CW       = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam bit IS_FWFT = (FWFT == int'(FIFO_FWFT));

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ok, wr_ok;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && !flush),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_ok) begin
        rd_ptr_d     = ptr_inc(rd_ptr_q);
        dout_d       = rd_data;
        dout_valid_d = 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CW'(1);
      end else if (!wr_ok && rd_ok) begin
        count_d = count_q - CW'(1);
      end
      // A new error in the same cycle beats clear_err.
      if (push && !wr_ok) begin
        overflow_d = 1'b1;
      end
      if (pop && !rd_ok) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout       = IS_FWFT ? rd_data : dout_q;
  assign dout_valid = IS_FWFT ? !empty  : dout_valid_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Three FIFO configurations share one stimulus stream; a queue model per instance predicts every output.
module tb_sync_fifo_ext;

  localparam int N = 3;
  localparam int DEP [N] = '{16, 5, 6};
  localparam int FW  [N] = '{0, 0, 1};
  localparam int AFL [N] = '{14, 3, 6};
  localparam int AEL [N] = '{2, 2, 0};

  logic       clk = 1'b0;
  logic       rst_n, flush, push, pop, clear_err;
  logic [7:0] din;

  always #5 clk = ~clk;

  logic [7:0] a_dout  [N];
  logic       a_dv    [N];
  logic       a_full  [N];
  logic       a_empty [N];
  logic       a_af    [N];
  logic       a_ae    [N];
  logic       a_ov    [N];
  logic       a_un    [N];
  int         a_cnt   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [$clog2(DEP[g]+1)-1:0] cnt_w;
    sync_fifo_ext #(
      .WIDTH    (8),
      .DEPTH    (DEP[g]),
      .FWFT     (FW[g]),
      .AF_LEVEL (AFL[g]),
      .AE_LEVEL (AEL[g])
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .push         (push),
      .din          (din),
      .pop          (pop),
      .dout         (a_dout[g]),
      .dout_valid   (a_dv[g]),
      .full         (a_full[g]),
      .empty        (a_empty[g]),
      .almost_full  (a_af[g]),
      .almost_empty (a_ae[g]),
      .count        (cnt_w),
      .overflow     (a_ov[g]),
      .underflow    (a_un[g]),
      .clear_err    (clear_err)
    );
    assign a_cnt[g] = int'(cnt_w);
  end

  typedef logic [7:0] bq_t [$];
  bq_t        mq     [N];
  logic [7:0] m_dout [N];
  bit         m_dv   [N];
  bit         m_ov   [N];
  bit         m_un   [N];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(input string name, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endfunction

  // Queue model: occupancy is the queue size, read order is queue order.
  task automatic model_update();
    for (int k = 0; k < N; k++) begin
      bit rd, wr, ov_set, un_set;
      if (!rst_n) begin
        mq[k].delete();
        m_dout[k] = 8'h00;
        m_dv[k]   = 1'b0;
        m_ov[k]   = 1'b0;
        m_un[k]   = 1'b0;
      end else begin
        ov_set = 1'b0;
        un_set = 1'b0;
        if (flush) begin
          mq[k].delete();
          m_dv[k]   = 1'b0;
          m_dout[k] = 8'h00;
        end else begin
          rd = pop && (mq[k].size() > 0);
          wr = push && ((mq[k].size() < DEP[k]) || rd);
          ov_set  = push && !wr;
          un_set  = pop && !rd;
          m_dv[k] = rd;
          if (rd) m_dout[k] = mq[k].pop_front();
          if (wr) mq[k].push_back(din);
        end
        if (ov_set) m_ov[k] = 1'b1;
        else if (clear_err) m_ov[k] = 1'b0;
        if (un_set) m_un[k] = 1'b1;
        else if (clear_err) m_un[k] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        int sz;
        sz = mq[k].size();
        chk("count",        k, a_cnt[k],          sz);
        chk("full",         k, int'(a_full[k]),   int'(sz == DEP[k]));
        chk("empty",        k, int'(a_empty[k]),  int'(sz == 0));
        chk("almost_full",  k, int'(a_af[k]),     int'(sz >= AFL[k]));
        chk("almost_empty", k, int'(a_ae[k]),     int'(sz <= AEL[k]));
        chk("overflow",     k, int'(a_ov[k]),     int'(m_ov[k]));
        chk("underflow",    k, int'(a_un[k]),     int'(m_un[k]));
        if (FW[k] != 0) begin
          chk("dout_valid", k, int'(a_dv[k]), int'(sz > 0));
          if (sz > 0) chk("dout", k, int'(a_dout[k]), int'(mq[k][0]));
        end else begin
          chk("dout_valid", k, int'(a_dv[k]),   int'(m_dv[k]));
          chk("dout",       k, int'(a_dout[k]), int'(m_dout[k]));
        end
      end
    end
  end

  task automatic step(input bit p, input logic [7:0] d, input bit po,
                      input bit f = 1'b0, input bit c = 1'b0, input bit r = 1'b1);
    push      = p;
    din       = d;
    pop       = po;
    flush     = f;
    clear_err = c;
    rst_n     = r;
    @(posedge clk);
    model_update();
    #2;
  endtask

  initial begin
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_empty", 0, int'(a_empty[0]), 1);
    chk("rst_full",  0, int'(a_full[0]),  0);
    chk("rst_ae",    0, int'(a_ae[0]),    1);
    chk("rst_af",    0, int'(a_af[0]),    0);
    chk("rst_count", 0, a_cnt[0],         0);
    chk("rst_dv",    0, int'(a_dv[0]),    0);

    // Fill to full; almost_full turns on at occupancy 14.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0);
      if (i == 12) chk("af_at13", 0, int'(a_af[0]), 0);
      if (i == 13) chk("af_at14", 0, int'(a_af[0]), 1);
    end
    chk("fill_full",  0, int'(a_full[0]), 1);
    chk("fill_count", 0, a_cnt[0],        16);
    step(1, 8'hAA, 0);
    chk("ovf_set",   0, int'(a_ov[0]),   1);
    chk("ovf_full",  0, int'(a_full[0]), 1);
    chk("ovf_count", 0, a_cnt[0],        16);

    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1);
      chk("drain_dout", 0, int'(a_dout[0]), i);
      chk("drain_dv",   0, int'(a_dv[0]),   1);
    end
    chk("drain_empty", 0, int'(a_empty[0]), 1);
    step(0, 8'h00, 1);
    chk("unf_set", 0, int'(a_un[0]), 1);
    chk("unf_dv",  0, int'(a_dv[0]), 0);
    step(0, 8'h00, 1, 0, 1);
    chk("unf_set_beats_clear", 0, int'(a_un[0]), 1);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_ovf", 0, int'(a_ov[0]), 0);
    chk("clr_unf", 0, int'(a_un[0]), 0);

    // Pop at empty alongside a push: pop refused, push taken.
    step(1, 8'h33, 1);
    chk("empty_pp_count", 0, a_cnt[0],        1);
    chk("empty_pp_unf",   0, int'(a_un[0]),   1);
    step(0, 8'h00, 1, 0, 1);
    chk("empty_pp_dout",  0, int'(a_dout[0]), 8'h33);

    // Push at full with a simultaneous pop.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h55, 1);
    chk("pf_dout",  0, int'(a_dout[0]), 8'h20);
    chk("pf_count", 0, a_cnt[0],        16);
    chk("pf_ovf",   0, int'(a_ov[0]),   0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    chk("pf_last", 0, int'(a_dout[0]), 8'h55);
    step(0, 8'h00, 0, 0, 1);

    // Fill/drain rounds that wrap the depth-5 and depth-6 instances.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + r * 16 + i), 0);
      chk("d5_fill_count", 1, a_cnt[1], 5);
      for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + r * 8 + i), 1);
      if (r == 0) chk("d5_wrap_dout", 1, int'(a_dout[1]), 8'h43);
      for (int i = 0; i < 7; i++) step(0, 8'h00, 1);
      chk("d5_drain_empty", 1, int'(a_empty[1]), 1);
      step(0, 8'h00, 0, 0, 1);
    end

    // First-word-fall-through instance.
    step(1, 8'h11, 0);
    chk("fwft_dout", 2, int'(a_dout[2]), 8'h11);
    chk("fwft_dv",   2, int'(a_dv[2]),   1);
    step(0, 8'h00, 0);
    chk("fwft_hold", 2, int'(a_dout[2]), 8'h11);
    step(0, 8'h00, 1);
    chk("fwft_pop_empty", 2, int'(a_empty[2]), 1);
    chk("fwft_pop_dv",    2, int'(a_dv[2]),    0);

    // Flush overrides a simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h90 + i), 0);
    step(1, 8'hEE, 1, 1);
    chk("flush_count", 0, a_cnt[0],         0);
    chk("flush_empty", 0, int'(a_empty[0]), 1);
    chk("flush_ovf",   0, int'(a_ov[0]),    0);
    chk("flush_unf",   0, int'(a_un[0]),    0);
    chk("flush_dv",    0, int'(a_dv[0]),    0);
    chk("flush_dout",  0, int'(a_dout[0]),  0);
    step(1, 8'h77, 0);
    chk("post_flush_fwft", 2, int'(a_dout[2]), 8'h77);
    step(0, 8'h00, 1);
    chk("post_flush_dout", 0, int'(a_dout[0]), 8'h77);

    // Reset in the middle of traffic discards contents.
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 0, 0, 0, 0);
    chk("midrst_count", 0, a_cnt[0],         0);
    chk("midrst_empty", 0, int'(a_empty[0]), 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous single-clock FIFO, the successor to the team's basic push/pop FIFO. Adds non-power-of-two depth, a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, push-at-full when a pop is accepted in the same cycle, synchronous flush, and sticky overflow/underflow error flags. Sits between producer and consumer datapaths as a rate-decoupling buffer.

## Interface
- WIDTH, 8: data word width in bits (>=1)
- DEPTH, 16: number of entries (>=2, any integer)
- FWFT, 0: 0 = standard read (dout registered on pop), 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- CW (derived, not overridable): $clog2(DEPTH+1)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents
- push  in  1  write request
- din  in  WIDTH  write data
- pop  in  1  read request
- dout  out  WIDTH  read data
- dout_valid  out  1  dout holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  current occupancy
- overflow  out  1  sticky: push rejected
- underflow  out  1  sticky: pop rejected
- clear_err  in  1  clears overflow/underflow

## Operation
- Reset (rst_n=0 at edge): wr_ptr=rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0). Reset mid-operation discards all contents.
- rd_ok = pop && !empty. wr_ok = push && (!full || rd_ok).
- Push at full with accepted pop: both proceed, count unchanged, no overflow.
- Pop at empty with push: pop rejected (no bypass), underflow set, push accepted.
- Pointers wrap explicitly from DEPTH-1 to 0 (no power-of-two assumption).
- count += wr_ok - rd_ok; never exceeds DEPTH or goes below 0.
- Standard mode (FWFT=0): on rd_ok, dout <= mem[rd_ptr] and dout_valid <= 1; otherwise dout holds and dout_valid <= 0.
- FWFT mode: dout = mem[rd_ptr] whenever !empty, dout_valid = !empty; pop consumes the shown word; dout value when empty is don't-care.
- flush=1: pointers and count to 0, dout_valid=0, dout=0 (standard mode); push/pop that cycle ignored; no error flags set; sticky flags unaffected.
- overflow <= 1 on push && !wr_ok; underflow <= 1 on pop && !rd_ok; clear_err clears both; set wins over clear in same cycle.
- Priority: rst_n > flush > push/pop.

## Timing
- Write-to-read latency: word pushed at edge N visible via empty=0 after edge N; standard mode pop at edge N+1 presents it on dout after N+1; FWFT shows it on dout after edge N.
- full, empty, almost_* decode combinationally from registered count; they change only after a clock edge.
- Full throughput: one push and one pop per cycle sustained at any occupancy including full.
- Sticky flags assert the cycle after the offending request.

## Structure
- Package fifo_pkg: no typedefs required; holds shared helper function for CW sizing and a localparam-free mode enum (FIFO_STD=0, FIFO_FWFT=1).
- Sub-module fifo_ram: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port; sync_fifo_ext holds pointers, count, flags, dout register.
- Target 150-250 lines RTL total.

## Test plan
- Reset, push 0..15 (DEPTH=16) -> full=1, almost_full from count 14, count=16; push 0xAA -> ignored, overflow=1, full=1.
- Pop 16 times (standard) -> dout 0..15 in order one cycle per pop, empty=1; extra pop -> underflow=1; clear_err -> both flags 0.
- DEPTH=5 non-pow2, 3 full fill/drain cycles with interleaved push/pop -> data order preserved across wrap, count never >5.
- At full, push 0x55 with pop -> dout=oldest word, count stays 16, overflow stays 0; last word read out is 0x55.
- FWFT=1: push 0x11 -> dout=0x11, dout_valid=1 the next cycle without pop; pop -> empty=1, dout_valid=0.
- Push 4 words then flush with push+pop asserted -> count=0, empty=1, no error flags; next push 0x77 then pop -> dout=0x77.
